// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one fixed-latency, single-ported memory
// between instruction fetch and data accesses, with one-cycle ready pulses and a pipeline stall.
module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises its request with stable address/data and holds it until
    // it sees its one-cycle ready pulse; dropping it earlier discards the result (flush).

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    logic [1:0]       state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] cnt;

    logic dm_req;
    logic grant_any;
    logic grant_dm;
    logic owner_req;

    assign dm_req    = dm_read | dm_write;
    assign grant_any = if_req | dm_req;
    assign owner_req = (owner == OWNER_DM) ? dm_req : if_req;
    assign dbg_state = state;

    // On a conflict the requester that did not win last time is served.
    always_comb begin
        grant_dm = 1'b0;
        if (dm_req && (!if_req || last_owner == OWNER_IF)) begin
            grant_dm = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWNER_IF;
            last_owner <= OWNER_IF;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_dm;
                        mem_addr  <= grant_dm ? dm_addr : if_addr;
                        mem_we    <= grant_dm & dm_write;
                        mem_wdata <= grant_dm ? dm_wdata : '0;
                        mem_en    <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt    <= CNT_LOAD;
                    mem_en <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        // A withdrawn request still finishes its memory access but returns nothing.
                        if (owner_req) begin
                            if (owner == OWNER_DM) begin
                                dm_ready <= 1'b1;
                                if (!mem_we) begin
                                    dm_rdata <= mem_rdata;
                                end
                            end else begin
                                if_ready <= 1'b1;
                                if_rdata <= mem_rdata;
                            end
                        end
                        last_owner <= owner;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (load/store data accesses) of the pipelined CPU. It serialises the two request streams with round-robin priority and runs each access through an issue/wait/complete sequence. It returns one-cycle ready pulses with read data and drives a pipeline-wide stall while any request is outstanding.

## Interface
- MEM_LATENCY, 2, number of clock edges from the memory sampling an access to read data being valid; legal range 1..15
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch stage requests an instruction read; held until if_ready
- if_addr  in  32  instruction byte address, stable while if_req
- if_ready  out  1  one-cycle pulse: instruction read complete
- if_rdata  out  32  instruction word, valid while if_ready; holds last value otherwise
- dm_read  in  1  memory stage load request; held until dm_ready
- dm_write  in  1  memory stage store request; held until dm_ready
- dm_addr  in  32  data byte address, stable while request held
- dm_wdata  in  32  store data, stable while dm_write
- dm_ready  out  1  one-cycle pulse: load or store complete
- dm_rdata  out  32  load word, valid while dm_ready after a load; unchanged by stores
- stall  out  1  freeze the pipeline: an asserted request is not completing this cycle
- mem_en  out  1  registered; memory samples an access on the edge ending a cycle with mem_en=1
- mem_we  out  1  registered; 1 = write
- mem_addr  out  32  registered access address
- mem_wdata  out  32  registered write data
- mem_rdata  in  32  read data from memory, valid in the cycle MEM_LATENCY edges after the sampling edge

## Operation
- States: IDLE, ISSUE, WAIT, DONE; owner register (IF or DM); last_owner register; down-counter cnt, width $clog2(MEM_LATENCY+1).
- IDLE: data request = dm_read|dm_write. If only one requester is asserted, grant it. If both are asserted, grant the one that is not last_owner. On a grant, latch owner, mem_addr, mem_we (=dm_write for DM, 0 for IF) and mem_wdata, set mem_en=1, and go to ISSUE. With no request, stay in IDLE with mem_en=0.
- dm_read and dm_write both high: treated as a store (write wins).
- ISSUE (1 cycle): mem_en=1 visible; load cnt=MEM_LATENCY; go to WAIT; mem_en=0 next cycle.
- WAIT: decrement cnt each edge. On the edge where cnt==1, capture mem_rdata into if_rdata or dm_rdata (per owner; no capture for a store). Assert the owner's ready for the next cycle, set last_owner=owner, and go to DONE.
- DONE (1 cycle): ready pulse visible; requests are ignored in this cycle so the held request is not reissued; go to IDLE.
- Withdrawn request: if the owner's request is deasserted at the capture edge (flush), the memory access still completes. The data is discarded, no ready pulse is produced and rdata is unchanged, and the FSM still passes through DONE.
- stall = (if_req & ~if_ready) | ((dm_read|dm_write) & ~dm_ready); combinational from registered ready.
- Addresses and data pass through unmodified; there is no alignment checking.

## Timing
- Request first seen in IDLE in cycle 0: mem_en=1 in cycle 1; mem_rdata valid in cycle 1+MEM_LATENCY; ready pulse in cycle 2+MEM_LATENCY; back in IDLE in cycle 3+MEM_LATENCY.
- Back-to-back throughput: one access per MEM_LATENCY+3 cycles.
- Reset: state=IDLE, owner=IF, last_owner=IF (first conflict grants DM), cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0. stall then follows the inputs.
- Reset mid-transaction: the in-flight access is abandoned; no ready pulse is produced and read data is discarded.
- A ready pulse never lasts more than 1 cycle. if_ready and dm_ready are never high in the same cycle.

## Test plan
- MEM_LATENCY=2, reset, then if_req=1 with if_addr=0x0000_0040 and mem_rdata=0x2008_0005 in cycle 3 -> mem_en=1 in cycle 1 with mem_addr=0x40 and mem_we=0; if_ready=1 and if_rdata=0x2008_0005 in cycle 4 only; stall=1 in cycles 0-3.
- Store dm_write=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> cycle 1: mem_en=1, mem_we=1, mem_wdata=0xDEAD_BEEF; dm_ready in cycle 4; dm_rdata unchanged.
- if_req and dm_read asserted together after reset -> DM granted first and dm_ready in cycle 4. IF is then issued from IDLE in cycle 5 (mem_en cycle 6) and if_ready in cycle 9. Repeat with both still asserted -> the grants alternate.
- Load-use sequence: dm_read held across the DONE cycle -> exactly one memory access and one dm_ready pulse; no reissue.
- if_req dropped during WAIT (flush) -> mem access completes; no if_ready, if_rdata unchanged, FSM reaches IDLE at cycle 5.
- reset asserted in WAIT -> next cycle all outputs are at reset values, no ready pulse; MEM_LATENCY=1 and 15 sweeps give ready at cycles 3 and 17.
